// File: rtl/nested_loop_counter_if.sv
// Control/status bundle between a sweep controller and the nested loop counter.
// The master steps and stalls the index tuple; the counter drives the tuple and its flags.
interface nested_loop_counter_if #(
  parameter int LEVELS = 4,
  parameter int CNT_W  = 32
);
  logic                    start;
  logic                    clear;
  logic                    advance;
  logic [LEVELS*CNT_W-1:0] bound;
  logic [LEVELS*CNT_W-1:0] count;
  logic                    valid;
  logic [LEVELS-1:0]       is_max;
  logic [LEVELS-1:0]       wrap;
  logic                    last;
  logic                    done;

  modport master (
    output start, clear, advance, bound,
    input  count, valid, is_max, wrap, last, done
  );

  modport slave (
    input  start, clear, advance, bound,
    output count, valid, is_max, wrap, last, done
  );
endinterface

// File: rtl/nested_loop_counter.sv
// N-level nested loop counter: level 0 is innermost, all levels roll over through
// a same-cycle carry chain, driven by a start/advance/done handshake.
module nested_loop_counter #(
  parameter int LEVELS = 4,
  parameter int CNT_W  = 32
) (
  input logic                  clk,
  input logic                  rstn,
  nested_loop_counter_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt_q [LEVELS];
  logic [CNT_W-1:0]  bnd_q [LEVELS];
  logic              valid_q;
  logic              done_q;

  logic [LEVELS-1:0] is_max;
  logic [LEVELS-1:0] chain;
  logic [LEVELS-1:0] wrap;
  logic [LEVELS-1:0] inc;
  logic              step;
  logic              last;
  logic              acc;

  // Carry chain: a level wraps only when it and every faster level sit at their maximum.
  always_comb begin
    step = bus.advance & valid_q;
    for (int k = 0; k < LEVELS; k++) begin
      is_max[k] = (cnt_q[k] == bnd_q[k] - CNT_W'(1));
    end
    for (int k = 0; k < LEVELS; k++) begin
      acc = 1'b1;
      for (int j = 0; j <= k; j++) begin
        acc = acc & is_max[j];
      end
      chain[k] = acc;
    end
    wrap   = chain & {LEVELS{step}};
    inc    = '0;
    inc[0] = step;
    for (int k = 1; k < LEVELS; k++) begin
      inc[k] = wrap[k-1];
    end
    last = valid_q & chain[LEVELS-1];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < LEVELS; k++) begin
        cnt_q[k] <= '0;
        bnd_q[k] <= CNT_W'(1);
      end
    end else if (bus.clear) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < LEVELS; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= RUN;
            valid_q <= 1'b1;
            // A zero trip count would never reach its maximum, so it runs once instead.
            for (int k = 0; k < LEVELS; k++) begin
              cnt_q[k] <= '0;
              if (bus.bound[k*CNT_W +: CNT_W] == '0) begin
                bnd_q[k] <= CNT_W'(1);
              end else begin
                bnd_q[k] <= bus.bound[k*CNT_W +: CNT_W];
              end
            end
          end
        end
        RUN: begin
          if (step && last) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            for (int k = 0; k < LEVELS; k++) begin
              cnt_q[k] <= '0;
            end
          end else begin
            for (int k = 0; k < LEVELS; k++) begin
              if (wrap[k]) begin
                cnt_q[k] <= '0;
              end else if (inc[k]) begin
                cnt_q[k] <= cnt_q[k] + CNT_W'(1);
              end
            end
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < LEVELS; g++) begin : g_pack
    assign bus.count[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  assign bus.valid  = valid_q;
  assign bus.done   = done_q;
  assign bus.is_max = is_max;
  assign bus.wrap   = wrap;
  assign bus.last   = last;

endmodule

// File: tb/tb_nested_loop_counter.sv
// Scoreboard bench for nested_loop_counter: the driver enumerates each sweep with
// mixed-radix arithmetic into a queue; the monitor pops and compares every consumed tuple.
module tb_nested_loop_counter;

  localparam int LEVELS = 4;
  localparam int CNT_W  = 32;

  typedef struct {
    logic [LEVELS*CNT_W-1:0] cnt;
    logic [LEVELS-1:0]       is_max;
    logic [LEVELS-1:0]       wrap;
    logic                    last;
  } exp_t;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  int   pops;
  int   wrap2_cnt;
  exp_t exp_q[$];
  exp_t e;
  logic exp_done;
  logic nxt_done;

  nested_loop_counter_if #(.LEVELS(LEVELS), .CNT_W(CNT_W)) bus ();

  nested_loop_counter #(.LEVELS(LEVELS), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Enumerate every tuple of the sweep as a mixed-radix number, level 0 least significant.
  task automatic push_sweep(input int unsigned b[LEVELS]);
    int unsigned eff[LEVELS];
    int unsigned total;
    int unsigned rem;
    int unsigned digit;
    exp_t        x;
    logic        all_max;
    total = 1;
    for (int k = 0; k < LEVELS; k++) begin
      eff[k] = (b[k] == 0) ? 1 : b[k];
      total  = total * eff[k];
    end
    for (int unsigned n = 0; n < total; n++) begin
      rem     = n;
      all_max = 1'b1;
      x.cnt   = '0;
      for (int k = 0; k < LEVELS; k++) begin
        digit                    = rem % eff[k];
        rem                      = rem / eff[k];
        x.cnt[k*CNT_W +: CNT_W]  = CNT_W'(digit);
        x.is_max[k]              = (digit == eff[k] - 1);
        all_max                  = all_max & x.is_max[k];
        x.wrap[k]                = all_max;
      end
      x.last = (n == total - 1);
      exp_q.push_back(x);
    end
  endtask

  task automatic apply_stimulus(input int unsigned b[LEVELS]);
    for (int k = 0; k < LEVELS; k++) begin
      bus.bound[k*CNT_W +: CNT_W] = CNT_W'(b[k]);
    end
    bus.start   = 1'b1;
    bus.advance = 1'($urandom_range(0, 1));
    push_sweep(b);
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.advance = 1'b0;
    check_output("valid_rise", 128'(bus.valid), 128'(1));
  endtask

  // mode 0: advance held, 1: pattern 1,0,0, 2: random advance with bound churn
  task automatic run_adv(input int mode, input int budget);
    int cyc;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < budget) begin
      case (mode)
        0:       bus.advance = 1'b1;
        1:       bus.advance = (cyc % 3 == 0);
        default: begin
          bus.advance = ($urandom_range(0, 3) != 0);
          bus.bound   = {$urandom, $urandom, $urandom, $urandom};
        end
      endcase
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.advance = 1'b0;
    check_output("done_within_budget", 128'(bus.done), 128'(1));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare the presented tuple against the queue head; pop on consumption.
  always @(negedge clk) begin
    if (!rstn) begin
      exp_done = 1'b0;
    end else begin
      check_output("done", 128'(bus.done), 128'(exp_done));
      nxt_done = 1'b0;
      if (bus.valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL extra_tuple: got count %0h expected no tuple at %0t", bus.count, $time);
        end else begin
          e = exp_q[0];
          check_output("count", bus.count, e.cnt);
          check_output("is_max", 128'(bus.is_max), 128'(e.is_max));
          check_output("last", 128'(bus.last), 128'(e.last));
          check_output("wrap", 128'(bus.wrap), bus.advance ? 128'(e.wrap) : 128'(0));
          if (bus.advance) begin
            void'(exp_q.pop_front());
            pops++;
            if (bus.wrap[2]) wrap2_cnt++;
            nxt_done = e.last;
          end
        end
      end else begin
        check_output("idle_last", 128'(bus.last), 128'(0));
        check_output("idle_wrap", 128'(bus.wrap), 128'(0));
      end
      exp_done = nxt_done;
    end
  end

  initial begin
    int unsigned b[LEVELS];
    int unsigned b2[LEVELS];
    checks      = 0;
    errors      = 0;
    pops        = 0;
    wrap2_cnt   = 0;
    exp_done    = 1'b0;
    rstn        = 1'b0;
    bus.start   = 1'b0;
    bus.clear   = 1'b0;
    bus.advance = 1'b1;
    bus.bound   = '0;

    #12;
    check_output("rst_count", bus.count, 128'(0));
    check_output("rst_valid", 128'(bus.valid), 128'(0));
    check_output("rst_done", 128'(bus.done), 128'(0));
    check_output("rst_is_max", 128'(bus.is_max), 128'(4'hF));
    check_output("rst_wrap", 128'(bus.wrap), 128'(0));
    check_output("rst_last", 128'(bus.last), 128'(0));
    @(posedge clk);
    #3;
    rstn        = 1'b1;
    bus.advance = 1'b0;
    idle_cycles(2);

    $display("[TB] basic sweep");
    b = '{2, 3, 1, 2};
    pops = 0;
    apply_stimulus(b);
    run_adv(0, 100);
    check_output("basic_tuples", 128'(pops), 128'(12));
    idle_cycles(2);

    $display("[TB] stall sweep");
    pops = 0;
    apply_stimulus(b);
    run_adv(1, 200);
    check_output("stall_tuples", 128'(pops), 128'(12));
    idle_cycles(2);

    $display("[TB] zero and unit bounds");
    b = '{0, 1, 1, 5};
    pops = 0;
    apply_stimulus(b);
    run_adv(0, 100);
    check_output("zero_unit_tuples", 128'(pops), 128'(5));
    idle_cycles(2);

    $display("[TB] abort mid-sweep");
    b = '{2, 3, 1, 2};
    apply_stimulus(b);
    bus.advance = 1'b1;
    idle_cycles(5);
    bus.advance = 1'b0;
    bus.clear   = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    exp_q.delete();
    check_output("abort_count", bus.count, 128'(0));
    check_output("abort_valid", 128'(bus.valid), 128'(0));
    idle_cycles(1);
    check_output("abort_no_done", 128'(bus.done), 128'(0));

    $display("[TB] clear with start in idle");
    bus.clear = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    bus.start = 1'b0;
    check_output("clear_start_valid", 128'(bus.valid), 128'(0));
    idle_cycles(1);
    check_output("clear_start_valid2", 128'(bus.valid), 128'(0));

    $display("[TB] async reset mid-run");
    b = '{3, 2, 2, 2};
    apply_stimulus(b);
    bus.advance = 1'b1;
    idle_cycles(4);
    #2;
    rstn = 1'b0;
    #1;
    check_output("arst_count", bus.count, 128'(0));
    check_output("arst_valid", 128'(bus.valid), 128'(0));
    check_output("arst_is_max", 128'(bus.is_max), 128'(4'hF));
    check_output("arst_wrap", 128'(bus.wrap), 128'(0));
    exp_q.delete();
    @(posedge clk);
    #1;
    rstn        = 1'b1;
    bus.advance = 1'b0;
    idle_cycles(2);

    $display("[TB] back-to-back sweeps");
    b  = '{2, 2, 1, 1};
    b2 = '{3, 1, 2, 1};
    apply_stimulus(b);
    run_adv(0, 100);
    apply_stimulus(b2);
    run_adv(2, 200);
    idle_cycles(1);

    $display("[TB] randomized sweeps");
    for (int s = 0; s < 15; s++) begin
      for (int k = 0; k < LEVELS; k++) begin
        b[k] = $urandom_range(0, 3);
      end
      apply_stimulus(b);
      run_adv(2, 2000);
      if ($urandom_range(0, 1) == 1) idle_cycles(1);
    end
    idle_cycles(2);

    $display("[TB] reference shape");
    b = '{16, 4, 392, 3};
    pops      = 0;
    wrap2_cnt = 0;
    apply_stimulus(b);
    run_adv(0, 80000);
    check_output("ref_advances", 128'(pops), 128'(75264));
    check_output("ref_wrap2_pulses", 128'(wrap2_cnt), 128'(3));
    idle_cycles(3);

    check_output("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
